// File: rtl/lfsr_block_sync_pkg.sv
// Shared types, constants and helpers for the 64b/66b block synchronizer.
package lfsr_block_sync_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } sync_state_t;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    // Only the two transition patterns are legal sync headers.
    function automatic logic header_valid(input logic [1:0] hdr);
        return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    endfunction

endpackage

// File: rtl/lfsr_bit_aligner.sv
// Bit aligner: holds the previous valid word and extracts a block-wide
// window from {current, previous} at the current bit offset.
// A slip advances the offset by one bit, wrapping at the block width.
module lfsr_bit_aligner #(
    parameter int unsigned BLOCK_WIDTH  = 66,
    parameter int unsigned OFFSET_WIDTH = $clog2(BLOCK_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_WIDTH-1:0]  data_in,
    input  logic                    data_in_valid,
    input  logic                    slip,
    output logic [BLOCK_WIDTH-1:0]  window,
    output logic [OFFSET_WIDTH-1:0] offset
);

    logic [BLOCK_WIDTH-1:0]   prev;
    logic [2*BLOCK_WIDTH-1:0] joined;
    logic [2*BLOCK_WIDTH-1:0] shifted;

    // Remember the last valid word so a block may straddle two input words
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
        end else if (data_in_valid) begin
            prev <= data_in;
        end
    end

    // Bit offset; each slip moves the window one bit later in the stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            offset <= '0;
        end else if (slip) begin
            if (offset == OFFSET_WIDTH'(BLOCK_WIDTH - 1)) begin
                offset <= '0;
            end else begin
                offset <= offset + 1'b1;
            end
        end
    end

    // Barrel shift: prev holds the earlier bits, so offset 0 selects prev
    always_comb begin
        joined  = {data_in, prev};
        shifted = joined >> offset;
        window  = shifted[BLOCK_WIDTH-1:0];
    end

endmodule

// File: rtl/lfsr_block_sync.sv
// 64b/66b block synchronizer: slips the raw deserialized stream until sync
// headers align, runs the HUNT/LOCKED state machine and registers aligned
// header/payload words for the downstream descrambler.
// Optional statistics ports are enabled with LFSR_BLOCK_SYNC_STATS_EN.
module lfsr_block_sync
    import lfsr_block_sync_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = 64,
    parameter int unsigned LOCK_CNT      = 64,
    parameter int unsigned UNLOCK_CNT    = 16,
    parameter int unsigned SLIP_WAIT     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PAYLOAD_WIDTH+1:0] data_in,
    input  logic                     data_in_valid,
    output logic [PAYLOAD_WIDTH-1:0] data_out,
    output logic [1:0]               header_out,
    output logic                     data_out_valid,
    output logic                     block_lock
`ifdef LFSR_BLOCK_SYNC_STATS_EN
    ,
    output logic [15:0]              slip_count,
    output logic [15:0]              bad_header_count
`endif
);

    localparam int unsigned BLOCK_WIDTH  = PAYLOAD_WIDTH + 2;
    localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_WIDTH);
    localparam int unsigned CNT_W        = $clog2(LOCK_CNT + 1);
    localparam int unsigned INV_W        = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned WAIT_W       = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

    sync_state_t             state, state_nxt;
    logic [CNT_W-1:0]        sh_cnt, sh_cnt_nxt;
    logic [INV_W-1:0]        sh_invld_cnt, sh_invld_cnt_nxt;
    logic [WAIT_W-1:0]       wait_cnt, wait_cnt_nxt;
    logic                    slip;
    logic                    tested;
    logic                    hdr_ok;
    logic [BLOCK_WIDTH-1:0]  window;
    // Aligner position, not needed by the lock logic; kept for debug visibility
    logic [OFFSET_WIDTH-1:0] offset_unused;

    lfsr_bit_aligner #(
        .BLOCK_WIDTH  (BLOCK_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_aligner (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .slip          (slip),
        .window        (window),
        .offset        (offset_unused)
    );

    assign hdr_ok = header_valid(window[1:0]);
    assign tested = data_in_valid && (wait_cnt == '0);

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= HUNT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            wait_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
        end
    end

    // Lock FSM: header testing, window counting, slip and lock decisions
    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        wait_cnt_nxt     = wait_cnt;
        slip             = 1'b0;

        if (data_in_valid && (wait_cnt != '0)) begin
            wait_cnt_nxt = wait_cnt - 1'b1;
        end else if (tested) begin
            case (state)
                HUNT: begin
                    if (!hdr_ok) begin
                        slip = 1'b1;
                    end else if (sh_cnt == CNT_W'(LOCK_CNT - 1)) begin
                        state_nxt        = LOCKED;
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    // Unlock is checked before the window end so it wins a tie
                    if (!hdr_ok && (sh_invld_cnt == INV_W'(UNLOCK_CNT - 1))) begin
                        slip      = 1'b1;
                        state_nxt = HUNT;
                    end else if (sh_cnt == CNT_W'(LOCK_CNT - 1)) begin
                        sh_cnt_nxt       = '0;
                        sh_invld_cnt_nxt = '0;
                    end else begin
                        sh_cnt_nxt = sh_cnt + 1'b1;
                        if (!hdr_ok) begin
                            sh_invld_cnt_nxt = sh_invld_cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase

            if (slip) begin
                sh_cnt_nxt       = '0;
                sh_invld_cnt_nxt = '0;
                wait_cnt_nxt     = WAIT_W'(SLIP_WAIT);
            end
        end
    end

    // Output registers: every valid word is emitted, lock tracks next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            header_out     <= '0;
            data_out_valid <= 1'b0;
            block_lock     <= 1'b0;
        end else begin
            data_out_valid <= data_in_valid;
            block_lock     <= (state_nxt == LOCKED);
            if (data_in_valid) begin
                data_out   <= window[BLOCK_WIDTH-1:2];
                header_out <= window[1:0];
            end
        end
    end

`ifdef LFSR_BLOCK_SYNC_STATS_EN
    // Saturating diagnostics counters for slips and tested bad headers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slip_count       <= '0;
            bad_header_count <= '0;
        end else begin
            if (slip && (slip_count != '1)) begin
                slip_count <= slip_count + 16'd1;
            end
            if (tested && !hdr_ok && (bad_header_count != '1)) begin
                bad_header_count <= bad_header_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_block_sync.sv
// Self-checking bench for lfsr_block_sync (default build, stats disabled).
// A bit-stream model predicts every registered output; literal checks pin
// lock timing, offsets and reset behaviour at hand-computed word counts.
module tb_lfsr_block_sync;

    logic        clk;
    logic        rst;
    logic [65:0] data_in;
    logic        data_in_valid;
    logic [63:0] data_out;
    logic [1:0]  header_out;
    logic        data_out_valid;
    logic        block_lock;

    int unsigned checks = 0;
    int unsigned errors = 0;

    lfsr_block_sync #(
        .PAYLOAD_WIDTH (64),
        .LOCK_CNT      (64),
        .UNLOCK_CNT    (16),
        .SLIP_WAIT     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .header_out     (header_out),
        .data_out_valid (data_out_valid),
        .block_lock     (block_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The wire is viewed as one long bit stream preceded by 66 zero bits
    // (the empty history after reset). The n-th valid word (0-based) sees
    // the 66 stream bits starting at 66*n + offset.
    logic [65:0] hist[$];
    int unsigned m_off, m_wait, m_sh, m_inv;
    bit          m_lock;
    logic [63:0] e_data;
    logic [1:0]  e_hdr;
    bit          e_valid, e_lock;

    function automatic bit sbit(input int unsigned i);
        logic [65:0] t;
        if (i < 66) return 1'b0;
        t = hist[(i - 66) / 66];
        return t[(i - 66) % 66];
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int unsigned n;
        logic [65:0] w;
        bit good, do_slip;
        if (!rst) begin
            hist.delete();
            m_off = 0; m_wait = 0; m_sh = 0; m_inv = 0; m_lock = 0;
            e_data = '0; e_hdr = '0; e_valid = 0; e_lock = 0;
        end else if (data_in_valid) begin
            n = hist.size();
            hist.push_back(data_in);
            for (int j = 0; j < 66; j++) w[j] = sbit(66 * n + m_off + j);
            e_data = w[65:2];
            e_hdr = w[1:0];
            e_valid = 1;
            if (m_wait > 0) begin
                m_wait--;
            end else begin
                good = (w[1:0] == 2'b01) || (w[1:0] == 2'b10);
                do_slip = 0;
                if (!m_lock) begin
                    if (!good) do_slip = 1;
                    else begin
                        m_sh++;
                        if (m_sh == 64) begin m_lock = 1; m_sh = 0; m_inv = 0; end
                    end
                end else begin
                    m_sh++;
                    if (!good) m_inv++;
                    if (m_inv == 16) begin do_slip = 1; m_lock = 0; end
                    else if (m_sh == 64) begin m_sh = 0; m_inv = 0; end
                end
                if (do_slip) begin
                    m_off = (m_off + 1) % 66;
                    m_sh = 0; m_inv = 0; m_wait = 2;
                end
            end
            e_lock = m_lock;
        end else begin
            e_valid = 0;
        end
    end

    // Compare DUT against the model away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            check("data_out_valid", 66'(data_out_valid), 66'(e_valid));
            check("block_lock", 66'(block_lock), 66'(e_lock));
            if (e_valid) begin
                check("data_out", 66'(data_out), 66'(e_data));
                check("header_out", 66'(header_out), 66'(e_hdr));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [65:0] w, input logic v);
        data_in = w;
        data_in_valid = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [65:0] pat(input int unsigned i, input bit bad);
        logic [65:0] p;
        p = {2'b10, 32'hA5C3_0F96 + i, 32'h1E87_B4D2 ^ (i * 32'h9E37)};
        p[39:37] = bad ? 3'b011 : 3'b010;
        return p;
    endfunction

    logic [65:0] w_a, v_c, q;

    initial begin
        rst = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        w_a = '0; w_a[38] = 1'b1;
        v_c = 66'd1;
        repeat (3) @(posedge clk);
        #1;
        check("reset data_out", 66'(data_out), 66'd0);
        check("reset header_out", 66'(header_out), 66'd0);
        check("reset data_out_valid", 66'(data_out_valid), 66'd0);
        check("reset block_lock", 66'(block_lock), 66'd0);
        check("reset offset", 66'(dut.u_aligner.offset), 66'd0);
        rst = 1'b1;

        // Stream misaligned by 37 bits: offset k tested on word 1+3k,
        // offset 37 first tested on word 112, lock on word 175.
        for (int i = 1; i <= 174; i++) send(w_a, 1'b1);
        check("misalign37 lock before 64th good", 66'(block_lock), 66'd0);
        send(w_a, 1'b1);
        check("misalign37 lock on 64th good", 66'(block_lock), 66'd1);
        check("misalign37 header", 66'(header_out), 66'(2'b10));
        check("misalign37 payload", 66'(data_out), 66'd0);
        check("misalign37 offset", 66'(dut.u_aligner.offset), 66'd37);

        // Locked: 15 headers of 2'b11 in one window keep lock
        for (int i = 0; i < 3; i++) send(pat(i, 1'b0), 1'b1);
        for (int i = 0; i < 15; i++) send(pat(i + 10, 1'b1), 1'b1);
        for (int i = 0; i < 60; i++) send(pat(i + 40, 1'b0), 1'b1);
        check("15 bad keeps lock", 66'(block_lock), 66'd1);
        // 16 bad headers in the next window force unlock and one slip
        for (int i = 0; i < 16; i++) send(pat(i + 200, 1'b1), 1'b1);
        check("15th of 16 bad still locked", 66'(block_lock), 66'd1);
        send(pat(300, 1'b0), 1'b1);
        check("16th bad unlocks", 66'(block_lock), 66'd0);
        check("unlock slips offset", 66'(dut.u_aligner.offset), 66'd38);
        for (int i = 0; i < 65; i++) send(pat(i + 400, 1'b0), 1'b1);
        check("relock at 38 not yet", 66'(block_lock), 66'd0);
        send(pat(500, 1'b0), 1'b1);
        check("relock at 38", 66'(block_lock), 66'd1);

        // Asynchronous reset mid-lock clears outputs immediately
        rst = 1'b0;
        #2;
        check("midlock reset data_out", 66'(data_out), 66'd0);
        check("midlock reset header_out", 66'(header_out), 66'd0);
        check("midlock reset valid", 66'(data_out_valid), 66'd0);
        check("midlock reset lock", 66'(block_lock), 66'd0);
        check("midlock reset offset", 66'(dut.u_aligner.offset), 66'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Toggling valid during HUNT: only offset 65 aligns; it is first
        // tested on valid word 196 and lock comes with valid word 259.
        for (int i = 1; i <= 258; i++) begin
            send(v_c, 1'b1);
            send(v_c, 1'b0);
        end
        check("toggle lock before 259", 66'(block_lock), 66'd0);
        check("toggle valid low", 66'(data_out_valid), 66'd0);
        send(v_c, 1'b1);
        check("toggle lock on 259", 66'(block_lock), 66'd1);
        check("toggle valid high", 66'(data_out_valid), 66'd1);
        check("offset65 header", 66'(header_out), 66'(2'b10));
        check("offset65 offset", 66'(dut.u_aligner.offset), 66'd65);
        send(v_c, 1'b0);
        check("lock held while idle", 66'(block_lock), 66'd1);

        // Force unlock at offset 65: offset wraps to 0
        for (int i = 0; i < 15; i++) send(66'd0, 1'b1);
        check("wrap 15 bad still locked", 66'(block_lock), 66'd1);
        send(66'd0, 1'b1);
        check("wrap unlock", 66'(block_lock), 66'd0);
        check("wrap offset", 66'(dut.u_aligner.offset), 66'd0);
        // Two untested words, then 64 good tests: lock on the 66th word
        for (int i = 0; i < 65; i++) begin
            q = {32'h3C96_A5F0 ^ 32'(i), 32'h0F0F_1234 + 32'(i), 2'b01};
            send(q, 1'b1);
        end
        check("wrap relock not yet", 66'(block_lock), 66'd0);
        send({64'hDEAD_BEEF_0123_4567, 2'b01}, 1'b1);
        check("wrap relock after wait", 66'(block_lock), 66'd1);
        send('0, 1'b0);
        send('0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
